// File: rtl/msix_pkg.sv
// Shared types and constants for the MSI-X message issuer.
package msix_pkg;

  localparam int unsigned MSIX_ADDR_W = 64;
  localparam int unsigned MSIX_DATA_W = 32;
  localparam logic [3:0]  MSIX_BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    SEND   = 2'd2
  } msix_state_e;

  typedef struct packed {
    logic [MSIX_ADDR_W-1:0] addr;
    logic [MSIX_DATA_W-1:0] data;
    logic                   mask;
  } msix_tbl_entry_t;

  // Increment a vector index, wrapping at n (n need not be a power of two).
  function automatic int unsigned msix_wrap_inc(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/msix_rr_arbiter.sv
// Combinational round-robin picker: lowest set request at or after ptr, wrapping.
module msix_rr_arbiter #(
  parameter  int unsigned NUM_VEC = 8,
  localparam int unsigned IDX_W   = $clog2(NUM_VEC)
) (
  input  logic [NUM_VEC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  // Scan NUM_VEC candidates starting at ptr; first hit wins.
  always_comb begin
    int unsigned cand;
    cand      = 32'd0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int unsigned i = 0; i < NUM_VEC; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NUM_VEC) cand = cand - NUM_VEC;
      if (!any_grant && req[IDX_W'(cand)]) begin
        any_grant = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/msix_msg_issuer.sv
// MSI-X transmit side: tracks the PBA, looks up the vector table entry and
// issues one DWORD posted write per pending, unmasked vector.
// Optional: define MSIX_SENT_CNT_EN to add a saturating sent-message counter.
module msix_msg_issuer
  import msix_pkg::*;
#(
  parameter  int unsigned NUM_VEC = 8,
  localparam int unsigned IDX_W   = $clog2(NUM_VEC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   msix_enable,
  input  logic                   function_mask,
  input  logic [NUM_VEC-1:0]     irq_req,
  output logic                   tbl_rd_en,
  output logic [IDX_W-1:0]       tbl_rd_idx,
  input  logic [MSIX_ADDR_W-1:0] tbl_rd_addr,
  input  logic [MSIX_DATA_W-1:0] tbl_rd_data,
  input  logic                   tbl_rd_mask,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [MSIX_ADDR_W-1:0] tx_addr,
  output logic [MSIX_DATA_W-1:0] tx_data,
  output logic [3:0]             tx_be,
  output logic                   tx_is_64b,
  output logic [NUM_VEC-1:0]     pba,
  output logic                   busy
`ifdef MSIX_SENT_CNT_EN
  ,
  output logic [31:0]            sent_cnt
`endif
);

  msix_state_e            state, state_nxt;
  logic [IDX_W-1:0]       rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]       grant_idx;
  logic                   any_grant;
  logic                   gate_open;
  logic                   tx_hs;
  msix_tbl_entry_t        tbl_entry;
  logic [NUM_VEC-1:0]     pba_clr;

  logic                   rd_en_nxt;
  logic [IDX_W-1:0]       rd_idx_nxt;
  logic                   tx_valid_nxt;
  logic [MSIX_ADDR_W-1:0] tx_addr_nxt;
  logic [MSIX_DATA_W-1:0] tx_data_nxt;
  logic [3:0]             tx_be_nxt;
  logic                   tx_is_64b_nxt;

  assign gate_open = msix_enable && !function_mask;
  assign tx_hs     = tx_valid && tx_ready;
  assign tbl_entry = '{addr: tbl_rd_addr, data: tbl_rd_data, mask: tbl_rd_mask};

  msix_rr_arbiter #(.NUM_VEC(NUM_VEC)) u_arb (
    .req       (pba),
    .ptr       (rr_ptr),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; IDLE spends one extra cycle with tbl_rd_en high before LOOKUP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tbl_rd_en) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = tbl_entry.mask ? IDLE : SEND;
      SEND:    if (tx_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs, pointer and PBA clear.
  always_comb begin
    rd_en_nxt     = 1'b0;
    rd_idx_nxt    = tbl_rd_idx;
    tx_valid_nxt  = tx_valid;
    tx_addr_nxt   = tx_addr;
    tx_data_nxt   = tx_data;
    tx_be_nxt     = tx_be;
    tx_is_64b_nxt = tx_is_64b;
    rr_ptr_nxt    = rr_ptr;
    pba_clr       = '0;
    case (state)
      IDLE: begin
        if (!tbl_rd_en && gate_open && any_grant) begin
          rd_en_nxt  = 1'b1;
          rd_idx_nxt = grant_idx;
        end
      end
      LOOKUP: begin
        if (tbl_entry.mask) begin
          rr_ptr_nxt = IDX_W'(msix_wrap_inc(32'(tbl_rd_idx), NUM_VEC));
        end else begin
          tx_valid_nxt  = 1'b1;
          tx_addr_nxt   = tbl_entry.addr & ~MSIX_ADDR_W'(3);
          tx_data_nxt   = tbl_entry.data;
          tx_be_nxt     = MSIX_BE_ALL;
          tx_is_64b_nxt = |tbl_entry.addr[MSIX_ADDR_W-1:32];
        end
      end
      SEND: begin
        if (tx_hs) begin
          tx_valid_nxt = 1'b0;
          tx_be_nxt    = 4'h0;
          rr_ptr_nxt   = IDX_W'(msix_wrap_inc(32'(tbl_rd_idx), NUM_VEC));
          pba_clr      = NUM_VEC'(1) << tbl_rd_idx;
        end
      end
      default: ;
    endcase
  end

  // Output and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_rd_en  <= 1'b0;
      tbl_rd_idx <= '0;
      tx_valid   <= 1'b0;
      tx_addr    <= '0;
      tx_data    <= '0;
      tx_be      <= 4'h0;
      tx_is_64b  <= 1'b0;
      rr_ptr     <= '0;
      busy       <= 1'b0;
    end else begin
      tbl_rd_en  <= rd_en_nxt;
      tbl_rd_idx <= rd_idx_nxt;
      tx_valid   <= tx_valid_nxt;
      tx_addr    <= tx_addr_nxt;
      tx_data    <= tx_data_nxt;
      tx_be      <= tx_be_nxt;
      tx_is_64b  <= tx_is_64b_nxt;
      rr_ptr     <= rr_ptr_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

  // Pending bits: new events win over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pba <= '0;
    else        pba <= (pba & ~pba_clr) | irq_req;
  end

`ifdef MSIX_SENT_CNT_EN
  // Saturating count of completed message handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               sent_cnt <= 32'd0;
    else if (tx_hs && sent_cnt != 32'hFFFF_FFFF) sent_cnt <= sent_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_msix_msg_issuer.sv
// Scoreboard bench for msix_msg_issuer with a behavioural table and arbitration model.
`timescale 1ns/1ps
module tb_msix_msg_issuer;

  localparam int unsigned N = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        msix_enable;
  logic        function_mask;
  logic [N-1:0] irq_req;
  logic        tbl_rd_en;
  logic [2:0]  tbl_rd_idx;
  logic [63:0] tbl_rd_addr;
  logic [31:0] tbl_rd_data;
  logic        tbl_rd_mask;
  logic        tx_valid;
  logic        tx_ready;
  logic [63:0] tx_addr;
  logic [31:0] tx_data;
  logic [3:0]  tx_be;
  logic        tx_is_64b;
  logic [N-1:0] pba;
  logic        busy;
`ifdef MSIX_SENT_CNT_EN
  logic [31:0] sent_cnt;
`endif

  msix_msg_issuer #(.NUM_VEC(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .msix_enable   (msix_enable),
    .function_mask (function_mask),
    .irq_req       (irq_req),
    .tbl_rd_en     (tbl_rd_en),
    .tbl_rd_idx    (tbl_rd_idx),
    .tbl_rd_addr   (tbl_rd_addr),
    .tbl_rd_data   (tbl_rd_data),
    .tbl_rd_mask   (tbl_rd_mask),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_addr       (tx_addr),
    .tx_data       (tx_data),
    .tx_be         (tx_be),
    .tx_is_64b     (tx_is_64b),
    .pba           (pba),
    .busy          (busy)
`ifdef MSIX_SENT_CNT_EN
    ,
    .sent_cnt      (sent_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          vec;
    logic [63:0] addr;
    logic [31:0] data;
    logic        is64;
  } exp_t;

  exp_t        q[$];
  logic [63:0] t_addr [N];
  logic [31:0] t_data [N];
  logic        t_mask [N];
  int n_chk = 0;
  int n_pass = 0;
  int hs_count = 0;
  int rd_cnt = 0;
  int mptr = 0;
  int ready_mode = 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Expected message for vector v from the current software table.
  function automatic void push_exp(input int v);
    exp_t e;
    e.vec  = v;
    e.addr = t_addr[v] & ~64'h3;
    e.data = t_data[v];
    e.is64 = (t_addr[v][63:32] != 32'h0);
    q.push_back(e);
  endfunction

  // Round-robin order from the model pointer over a pending set.
  function automatic void push_rr(input logic [N-1:0] pend);
    for (int k = 0; k < N; k++) begin
      int v;
      v = (mptr + k) % N;
      if (pend[v]) push_exp(v);
    end
  endfunction

  // Table read port: registered response, junk when no read was issued.
  always @(posedge clk) begin
    if (tbl_rd_en) begin
      tbl_rd_addr <= t_addr[tbl_rd_idx];
      tbl_rd_data <= t_data[tbl_rd_idx];
      tbl_rd_mask <= t_mask[tbl_rd_idx];
      rd_cnt      <= rd_cnt + 1;
    end else begin
      tbl_rd_addr <= {$urandom(), $urandom()};
      tbl_rd_data <= $urandom();
      tbl_rd_mask <= 1'($urandom());
    end
  end

  // Downstream ready generator.
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       tx_ready = 1'b0;
        1:       tx_ready = 1'b1;
        default: tx_ready = ($urandom_range(0, 99) < 60);
      endcase
    end
  end

  // Monitor: compare each presented message against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_msg: got data %h with empty scoreboard at %0t", tx_data, $time);
        end else begin
          chk("tx_addr", tx_addr, q[0].addr);
          chk("tx_data", 64'(tx_data), 64'(q[0].data));
          chk("tx_is_64b", 64'(tx_is_64b), 64'(q[0].is64));
          chk("tx_be", 64'(tx_be), 64'hF);
          if (tx_ready) begin
            mptr = (q[0].vec + 1) % N;
            void'(q.pop_front());
            hs_count++;
          end
        end
      end else begin
        chk("tx_be_idle", 64'(tx_be), 64'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!tx_valid && n < 30) begin
      tick();
      n++;
    end
    chk(name, 64'(tx_valid), 64'h1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(q.size() == 0 && !busy && !tx_valid) && n < 600) begin
      tick();
      n++;
    end
    chk(name, 64'(q.size() == 0 && !busy && !tx_valid), 64'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, hs0, rd0;
    logic [N-1:0] mpend;

    for (int v = 0; v < N; v++) begin
      t_addr[v] = {32'h0, 32'hFEE0_0000 | 32'(v << 4)};
      t_data[v] = 32'h40 + 32'(v);
      t_mask[v] = 1'b0;
    end
    rst_n = 1'b0;
    irq_req = '0;
    msix_enable = 1'b1;
    function_mask = 1'b0;
    tbl_rd_addr = '0;
    tbl_rd_data = '0;
    tbl_rd_mask = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", 64'(tx_valid), 64'h0);
    chk("rst_pba", 64'(pba), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_rd_en", 64'(tbl_rd_en), 64'h0);
    chk("rst_tx_addr", tx_addr, 64'h0);
    chk("rst_tx_be", 64'(tx_be), 64'h0);
    rst_n = 1'b1;
    tick();

    // Function mask gates arbitration but not PBA; then 0 before 5.
    function_mask = 1'b1;
    ready_mode = 1;
    rd0 = rd_cnt;
    irq_req = 8'h21;
    tick();
    irq_req = '0;
    repeat (8) tick();
    chk("fmask_pba", 64'(pba), 64'h21);
    chk("fmask_no_reads", 64'(rd_cnt - rd0), 64'h0);
    chk("fmask_busy", 64'(busy), 64'h0);
    push_rr(8'h21);
    chk("fmask_order_first", 64'(q[0].vec), 64'h0);
    function_mask = 1'b0;
    drain("fmask_drain");
    chk("fmask_pba_clear", 64'(pba), 64'h0);

    // Single event and minimum latency.
    t_addr[3] = 64'h0000_0000_FEE0_1004;
    t_data[3] = 32'h0000_0041;
    push_exp(3);
    irq_req = 8'h08;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        irq_req = '0;
        chk("single_pba_set", 64'(pba[3]), 64'h1);
      end
      if (n == 2) begin
        chk("single_rd_en", 64'(tbl_rd_en), 64'h1);
        chk("single_rd_idx", 64'(tbl_rd_idx), 64'h3);
      end
    end while (!tx_valid && n < 12);
    chk("single_latency", 64'(n), 64'd4);
    chk("single_addr", tx_addr, 64'h0000_0000_FEE0_1004);
    drain("single_drain");
    chk("single_pba_clear", 64'(pba), 64'h0);

    // Backpressure, then a new event on the handshake cycle.
    ready_mode = 0;
    push_exp(3);
    irq_req = 8'h08;
    tick();
    irq_req = '0;
    wait_valid("bp_valid");
    hs0 = hs_count;
    repeat (5) tick();
    chk("bp_no_hs", 64'(hs_count - hs0), 64'h0);
    push_exp(3);
    irq_req = 8'h08;
    ready_mode = 1;
    tick();
    irq_req = '0;
    chk("bp_one_hs", 64'(hs_count - hs0), 64'h1);
    chk("bp_pba_kept", 64'(pba[3]), 64'h1);
    drain("bp_drain");
    chk("bp_two_hs", 64'(hs_count - hs0), 64'h2);
    chk("bp_pba_clear", 64'(pba), 64'h0);

    // Per-vector mask holds the pending bit.
    t_mask[2] = 1'b1;
    hs0 = hs_count;
    rd0 = rd_cnt;
    irq_req = 8'h04;
    tick();
    irq_req = '0;
    repeat (20) tick();
    chk("vmask_pba", 64'(pba), 64'h04);
    chk("vmask_no_msg", 64'(hs_count - hs0), 64'h0);
    chk("vmask_lookups", 64'(rd_cnt != rd0), 64'h1);
    push_exp(2);
    t_mask[2] = 1'b0;
    drain("vmask_drain");
    chk("vmask_pba_clear", 64'(pba), 64'h0);

    // 64-bit address needs a 4DW header.
    t_addr[6] = 64'h0000_0001_0000_0007;
    ready_mode = 0;
    push_exp(6);
    irq_req = 8'h40;
    tick();
    irq_req = '0;
    wait_valid("a64_valid");
    chk("a64_addr", tx_addr, 64'h0000_0001_0000_0004);
    chk("a64_is64", 64'(tx_is_64b), 64'h1);
    ready_mode = 1;
    drain("a64_drain");

    // Random batches: events collected while gated, then drained in RR order.
    for (int b = 0; b < 8; b++) begin
      for (int v = 0; v < N; v++) begin
        t_addr[v] = ($urandom_range(0, 1) == 1) ? {$urandom(), $urandom()} : {32'h0, $urandom()};
        t_data[v] = $urandom();
      end
      if ($urandom_range(0, 1) == 1) function_mask = 1'b1;
      else                           msix_enable = 1'b0;
      mpend = '0;
      for (int c = 0; c < 10; c++) begin
        irq_req = N'($urandom() & $urandom());
        mpend |= irq_req;
        tick();
      end
      irq_req = '0;
      repeat (3) tick();
      chk("rand_pba_gated", 64'(pba), 64'(mpend));
      push_rr(mpend);
      ready_mode = 2;
      function_mask = 1'b0;
      msix_enable = 1'b1;
      drain("rand_drain");
      chk("rand_pba_clear", 64'(pba), 64'h0);
    end

    // Reset in the middle of SEND drops the message.
    ready_mode = 0;
    push_exp(1);
    irq_req = 8'h02;
    tick();
    irq_req = '0;
    wait_valid("rst_send_valid");
`ifdef MSIX_SENT_CNT_EN
    chk("sent_cnt_before_rst", 64'(sent_cnt), 64'(hs_count));
`endif
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", 64'(tx_valid), 64'h0);
    chk("midrst_pba", 64'(pba), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_tx_be", 64'(tx_be), 64'h0);
`ifdef MSIX_SENT_CNT_EN
    chk("midrst_sent_cnt", 64'(sent_cnt), 64'h0);
`endif
    q.delete();
    mptr = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("post_rst_idle", 64'(tx_valid | busy), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
